// File: rtl/p_cacheline_burst_adaptor_pkg.sv
// Shared types and line/burst geometry for the cache-line burst adaptor.
package cacheline_adaptor_types;

    localparam int S_OFFSET       = 5;
    localparam int LINE_W         = 256;
    localparam int BURST_W        = 64;
    localparam int BEATS_PER_LINE = LINE_W / BURST_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_DONE  = 3'd2,
        WR_BURST = 3'd3,
        WR_DONE  = 3'd4
    } cla_state_t;

endpackage

// File: rtl/p_cacheline_burst_adaptor_if.sv
// Cache-side line port and memory-side burst port of the adaptor.
// slave = adaptor view, master = cache + memory view.
interface p_cacheline_burst_adaptor_if;
    import cacheline_adaptor_types::*;

    logic                pmem_read;
    logic                pmem_write;
    logic [31:0]         pmem_address;
    logic [LINE_W-1:0]   pmem_wdata;
    logic [LINE_W-1:0]   pmem_rdata;
    logic                pmem_resp;
    logic                mem_read;
    logic                mem_write;
    logic [31:0]         mem_address;
    logic [BURST_W-1:0]  burst_o;
    logic [BURST_W-1:0]  burst_i;
    logic                mem_resp;

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, burst_i, mem_resp,
        output pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, burst_o
    );

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata, burst_i, mem_resp,
        input  pmem_rdata, pmem_resp, mem_read, mem_write, mem_address, burst_o
    );

endinterface

// File: rtl/p_cacheline_burst_adaptor_burst_line_buffer.sv
// Line register: 256 bits, written one 64-bit beat at a time or loaded whole.
// Latency: one cycle from write strobe to visible data; no backpressure.
module burst_line_buffer
    import cacheline_adaptor_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_beat_we,
    input  logic [1:0]         i_beat_idx,
    input  logic [BURST_W-1:0] i_beat_dat,
    input  logic               i_load,
    input  logic [LINE_W-1:0]  i_line,
    output logic [LINE_W-1:0]  o_line
);

    logic [LINE_W-1:0] r_line;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_line;
        end else if (i_beat_we) begin
            r_line[BURST_W*i_beat_idx +: BURST_W] <= i_beat_dat;
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/p_cacheline_burst_adaptor.sv
// Cache line <-> 4x64-bit burst adaptor; write-back path built only with CLA_WRITE_EN.
// Latency: accept 1 cycle, one beat per mem_resp, pmem_resp one cycle after the 4th beat.
// Backpressure: memory stalls by withholding mem_resp; cache holds request until pmem_resp.
module p_cacheline_burst_adaptor
    import cacheline_adaptor_types::*;
(
    input  logic                        clk,
    input  logic                        rst,
    p_cacheline_burst_adaptor_if.slave  bus
);

    cla_state_t        r_state;
    cla_state_t        w_next;
    logic [1:0]        r_cnt;
    logic [31:0]       r_addr;
    logic [LINE_W-1:0] r_rdata;
    logic [LINE_W-1:0] w_rbuf_line;
    logic              w_rd_go;
    logic              w_wr_go;
    logic              w_rd_beat;
    logic              w_wr_beat;
    logic              w_unused;

    always_comb begin
        w_next    = r_state;
        w_rd_go   = 1'b0;
        w_wr_go   = 1'b0;
        w_rd_beat = 1'b0;
        w_wr_beat = 1'b0;
        case (r_state)
            IDLE: begin
`ifdef CLA_WRITE_EN
                if (bus.pmem_write) begin
                    w_wr_go = 1'b1;
                    w_next  = WR_BURST;
                end else
`endif
                if (bus.pmem_read) begin
                    w_rd_go = 1'b1;
                    w_next  = RD_BURST;
                end
            end
            RD_BURST: begin
                if (bus.mem_resp) begin
                    w_rd_beat = 1'b1;
                    if (r_cnt == 2'd3) w_next = RD_DONE;
                end
            end
            RD_DONE: w_next = IDLE;
`ifdef CLA_WRITE_EN
            WR_BURST: begin
                if (bus.mem_resp) begin
                    w_wr_beat = 1'b1;
                    if (r_cnt == 2'd3) w_next = WR_DONE;
                end
            end
            WR_DONE: w_next = IDLE;
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_addr  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_rd_go || w_wr_go) begin
                r_cnt  <= 2'd0;
                r_addr <= {bus.pmem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
            end else if (w_rd_beat || w_wr_beat) begin
                r_cnt  <= r_cnt + 2'd1;
            end
            if (r_state == RD_DONE) r_rdata <= w_rbuf_line;
        end
    end

    burst_line_buffer u_rd_buf (
        .clk        (clk),
        .rst        (rst),
        .i_beat_we  (w_rd_beat),
        .i_beat_idx (r_cnt),
        .i_beat_dat (bus.burst_i),
        .i_load     (1'b0),
        .i_line     ('0),
        .o_line     (w_rbuf_line)
    );

    // The assembling buffer is only shown during RD_DONE so the previous line stays visible mid-fill.
    assign bus.pmem_rdata  = (r_state == RD_DONE) ? w_rbuf_line : r_rdata;
    assign bus.pmem_resp   = (r_state == RD_DONE) || (r_state == WR_DONE);
    assign bus.mem_read    = (r_state == RD_BURST);
    assign bus.mem_address = r_addr;

`ifdef CLA_WRITE_EN
    logic [LINE_W-1:0] w_wline;

    burst_line_buffer u_wr_buf (
        .clk        (clk),
        .rst        (rst),
        .i_beat_we  (1'b0),
        .i_beat_idx (2'd0),
        .i_beat_dat ('0),
        .i_load     (w_wr_go),
        .i_line     (bus.pmem_wdata),
        .o_line     (w_wline)
    );

    assign bus.mem_write = (r_state == WR_BURST);
    assign bus.burst_o   = (r_state == WR_BURST) ? w_wline[BURST_W*r_cnt +: BURST_W] : '0;
    assign w_unused      = ^bus.pmem_address[S_OFFSET-1:0];
`else
    assign bus.mem_write = 1'b0;
    assign bus.burst_o   = '0;
    assign w_unused      = ^{bus.pmem_write, bus.pmem_wdata, bus.pmem_address[S_OFFSET-1:0]};
`endif

endmodule

// File: tb/tb_p_cacheline_burst_adaptor.sv
// Bench for p_cacheline_burst_adaptor: directed vector table, hand sequences, random fills.
module tb_p_cacheline_burst_adaptor;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [255:0] exp_rdata;

    p_cacheline_burst_adaptor_if bus ();

    p_cacheline_burst_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       addr;
        logic [3:0][63:0]  beats;
        logic [31:0]       gap;
        int                drop_at;
        bit                stray;
        logic [31:0]       exp_addr;
        logic [255:0]      exp_line;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // One fill: cycle 0 request, burst cycles driven by gap pattern, then the done cycle.
    task automatic do_read(input logic [31:0] addr, input logic [3:0][63:0] beats,
                           input logic [31:0] gap, input int drop_at, input bit stray,
                           input logic [31:0] exp_addr, input logic [255:0] exp_line);
        int taken;
        int cyc;
        @(posedge clk); #1;
        bus.pmem_read    = 1'b1;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = addr;
        bus.mem_resp     = stray;
        bus.burst_i      = {$urandom, $urandom};
        @(negedge clk);
        chk("rd_idle_mem_read", {255'd0, bus.mem_read}, 256'd0);
        chk("rd_idle_resp", {255'd0, bus.pmem_resp}, 256'd0);
        chk("rd_idle_rdata_hold", bus.pmem_rdata, exp_rdata);
        taken = 0;
        cyc   = 0;
        while (taken < 4 && cyc < 48) begin
            @(posedge clk); #1;
            bus.mem_resp = (cyc >= 32) ? 1'b1 : gap[cyc];
            bus.burst_i  = bus.mem_resp ? beats[taken] : {$urandom, $urandom};
            if (taken >= drop_at) bus.pmem_read = 1'b0;
            @(negedge clk);
            chk("rd_mem_read", {255'd0, bus.mem_read}, 256'd1);
            chk("rd_mem_address", {224'd0, bus.mem_address}, {224'd0, exp_addr});
            chk("rd_resp_early", {255'd0, bus.pmem_resp}, 256'd0);
            chk("rd_rdata_hold", bus.pmem_rdata, exp_rdata);
            if (bus.mem_resp) taken++;
            cyc++;
        end
        if (taken < 4) chk("rd_beat_timeout", 256'(taken), 256'd4);
        @(posedge clk); #1;
        bus.pmem_read = 1'b0;
        bus.mem_resp  = 1'b1;
        bus.burst_i   = {$urandom, $urandom};
        @(negedge clk);
        chk("rd_done_resp", {255'd0, bus.pmem_resp}, 256'd1);
        chk("rd_done_mem_read", {255'd0, bus.mem_read}, 256'd0);
        chk("rd_done_rdata", bus.pmem_rdata, exp_line);
        exp_rdata = exp_line;
    endtask

`ifdef CLA_WRITE_EN
    task automatic do_write(input logic [31:0] addr, input logic [255:0] wdata, input bit keep_read,
                            input logic [3:0][63:0] exp_beats, input logic [31:0] exp_addr);
        int taken;
        int cyc;
        @(posedge clk); #1;
        bus.pmem_write   = 1'b1;
        bus.pmem_read    = keep_read;
        bus.pmem_address = addr;
        bus.pmem_wdata   = wdata;
        bus.mem_resp     = 1'b0;
        @(negedge clk);
        chk("wr_idle_mem_write", {255'd0, bus.mem_write}, 256'd0);
        taken = 0;
        cyc   = 0;
        while (taken < 4 && cyc < 40) begin
            @(posedge clk); #1;
            bus.mem_resp = (cyc >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("wr_mem_write", {255'd0, bus.mem_write}, 256'd1);
            chk("wr_mem_read", {255'd0, bus.mem_read}, 256'd0);
            chk("wr_mem_address", {224'd0, bus.mem_address}, {224'd0, exp_addr});
            chk("wr_burst_o", {192'd0, bus.burst_o}, {192'd0, exp_beats[taken]});
            chk("wr_resp_early", {255'd0, bus.pmem_resp}, 256'd0);
            if (bus.mem_resp) taken++;
            cyc++;
        end
        if (taken < 4) chk("wr_beat_timeout", 256'(taken), 256'd4);
        @(posedge clk); #1;
        bus.pmem_write = 1'b0;
        bus.mem_resp   = 1'b1;
        @(negedge clk);
        chk("wr_done_resp", {255'd0, bus.pmem_resp}, 256'd1);
        chk("wr_done_mem_write", {255'd0, bus.mem_write}, 256'd0);
        chk("wr_done_rdata_hold", bus.pmem_rdata, exp_rdata);
    endtask
`endif

    initial begin
        logic [3:0][63:0] rb;
        logic [31:0]      ra;
        logic [255:0]     wd;
        int               taken;
        checks    = 0;
        errors    = 0;
        exp_rdata = '0;
        rst              = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.burst_i      = '0;
        bus.mem_resp     = 1'b0;

        vecs[0] = '{addr: 32'h0000_1234,
                    beats: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    gap: 32'hFFFF_FFFF, drop_at: 99, stray: 1'b0, exp_addr: 32'h0000_1220,
                    exp_line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[1] = '{addr: 32'hABCD_EF7F,
                    beats: {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                            64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000},
                    gap: 32'h0000_0059, drop_at: 99, stray: 1'b0, exp_addr: 32'hABCD_EF60,
                    exp_line: {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                               64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000}};
        vecs[2] = '{addr: 32'hFFFF_FFFF,
                    beats: {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                            64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001},
                    gap: 32'h0000_00F3, drop_at: 1, stray: 1'b1, exp_addr: 32'hFFFF_FFE0,
                    exp_line: {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                               64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001}};

        #2;
        chk("reset_mem_read", {255'd0, bus.mem_read}, 256'd0);
        chk("reset_mem_write", {255'd0, bus.mem_write}, 256'd0);
        chk("reset_resp", {255'd0, bus.pmem_resp}, 256'd0);
        chk("reset_rdata", bus.pmem_rdata, 256'd0);
        chk("reset_mem_address", {224'd0, bus.mem_address}, 256'd0);
        chk("reset_burst_o", {192'd0, bus.burst_o}, 256'd0);
        #10 rst = 1'b1;

        for (int i = 0; i < 3; i++)
            do_read(vecs[i].addr, vecs[i].beats, vecs[i].gap, vecs[i].drop_at, vecs[i].stray,
                    vecs[i].exp_addr, vecs[i].exp_line);

`ifdef CLA_WRITE_EN
        wd = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        rb = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        do_write(32'h0000_8010, wd, 1'b0, rb, 32'h0000_8000);
        do_write(32'h0000_9020, wd, 1'b1, rb, 32'h0000_9020);
        do_read(32'h0000_9020, rb, 32'hFFFF_FFFF, 99, 1'b0, 32'h0000_9020, wd);
`else
        wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        bus.pmem_write = 1'b1;
        bus.pmem_wdata = wd;
        for (int c = 0; c < 8; c++) begin
            bus.mem_resp = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("nowr_mem_write", {255'd0, bus.mem_write}, 256'd0);
            chk("nowr_mem_read", {255'd0, bus.mem_read}, 256'd0);
            chk("nowr_resp", {255'd0, bus.pmem_resp}, 256'd0);
            chk("nowr_burst_o", {192'd0, bus.burst_o}, 256'd0);
            @(posedge clk); #1;
        end
        bus.pmem_write = 1'b0;
        bus.mem_resp   = 1'b0;
`endif

        // Reset after the second beat of a fill.
        @(posedge clk); #1;
        bus.pmem_read    = 1'b1;
        bus.pmem_address = 32'h5000_0040;
        bus.mem_resp     = 1'b0;
        @(negedge clk);
        taken = 0;
        while (taken < 2) begin
            @(posedge clk); #1;
            bus.mem_resp = 1'b1;
            bus.burst_i  = {$urandom, $urandom};
            @(negedge clk);
            chk("rstmid_mem_read", {255'd0, bus.mem_read}, 256'd1);
            taken++;
        end
        #2 rst = 1'b0;
        #1;
        chk("rstmid_mem_read_drop", {255'd0, bus.mem_read}, 256'd0);
        chk("rstmid_rdata", bus.pmem_rdata, 256'd0);
        exp_rdata        = '0;
        bus.pmem_read    = 1'b0;
        bus.mem_resp     = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstmid_no_resp", {255'd0, bus.pmem_resp}, 256'd0);
            chk("rstmid_idle", {255'd0, bus.mem_read}, 256'd0);
        end
        do_read(vecs[0].addr, vecs[0].beats, vecs[0].gap, 99, 1'b0, vecs[0].exp_addr, vecs[0].exp_line);

        // Random fills against the line model: beat k lands in bits [64k+63:64k].
        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            for (int k = 0; k < 4; k++) rb[k] = {$urandom, $urandom};
            do_read(ra, rb, $urandom, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                    ra & 32'hFFFF_FFE0, {rb[3], rb[2], rb[1], rb[0]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
